// File: rtl/adc_log_pkg.sv
// rtl/adc_log_pkg.sv - shared constants and state type for the ADC sample logger
package adc_log_pkg;

  localparam int ADC_W_DEF = 12;
  localparam int LED_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/adc_window_avg.sv
// rtl/adc_window_avg.sv - fixed-window averager over 2^AVG_LOG2 accepted samples
// Ports: clk, rst (async active-low), sample_valid/sample (accepted sample),
//        flush (discard partial window), avg_data/avg_valid (registered result),
//        avg_next/win_done (combinational view of the completing window).
module adc_window_avg #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic             flush,
  output logic [ADC_W-1:0] avg_data,
  output logic             avg_valid,
  output logic [ADC_W-1:0] avg_next,
  output logic             win_done
);

  // Wide enough for 2^AVG_LOG2 full-scale samples, so no overflow check.
  logic [ADC_W+AVG_LOG2-1:0] r_acc;
  logic [AVG_LOG2-1:0]       r_count;
  logic [ADC_W-1:0]          r_avg_data;
  logic                      r_avg_valid;
  logic [ADC_W+AVG_LOG2-1:0] w_sum;

  assign w_sum    = r_acc + {{AVG_LOG2{1'b0}}, sample};
  assign win_done = sample_valid && !flush && (r_count == {AVG_LOG2{1'b1}});
  assign avg_next = w_sum[ADC_W+AVG_LOG2-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_avg_data  <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (flush) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (sample_valid) begin
        if (win_done) begin
          // Window closes on this edge; the next sample opens a fresh window.
          r_acc       <= '0;
          r_count     <= '0;
          r_avg_data  <= avg_next;
          r_avg_valid <= 1'b1;
        end else begin
          r_acc   <= w_sum;
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign avg_data  = r_avg_data;
  assign avg_valid = r_avg_valid;

endmodule

// File: rtl/adc_sample_logger.sv
// rtl/adc_sample_logger.sv - logs ADC samples to sample RAM and drives LEDs with window averages
// Optional alarm comparator: define ADC_LOG_ALARM_EN.
// Ports: clk, rst (async active-low), enable, clear, adc_valid/adc_data (ADC stream),
//        alarm_thresh, ram_address/ram_data/ram_wren (RAM write port),
//        avg_data/avg_valid/led (averages), buf_full, sample_count, alarm.
module adc_sample_logger
  import adc_log_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int ADDR_W   = 8,
  parameter int AVG_LOG2 = 4,
  parameter int WRAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [ADC_W-1:0]  alarm_thresh,
  output logic [ADDR_W-1:0] ram_address,
  output logic [ADC_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic [ADC_W-1:0]  avg_data,
  output logic              avg_valid,
  output logic [LED_W-1:0]  led,
  output logic              buf_full,
  output logic [ADDR_W:0]   sample_count,
  output logic              alarm
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam bit              STOP_MODE = (WRAP == 0);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_ram_address;
  logic [ADC_W-1:0]  r_ram_data;
  logic              r_ram_wren;
  logic              r_buf_full;
  logic [ADDR_W:0]   r_sample_count;

  logic              w_accept;
  logic              w_write;
  logic              w_last;
  logic              w_flush;
  logic [ADC_W-1:0]  w_avg_data;
  logic              w_avg_valid;
  logic [ADC_W-1:0]  w_avg_next;
  logic              w_win_done;

  // A sample coincident with clear is dropped, as is anything outside RUN/FULL.
  assign w_accept = adc_valid && enable && !clear && (r_state == RUN || r_state == FULL);
  // Once a stop-mode buffer is full it stays write-protected until clear.
  assign w_write  = w_accept && (r_state == RUN) && !(STOP_MODE && r_buf_full);
  assign w_last   = (r_wr_ptr == {ADDR_W{1'b1}});
  // Dropping enable discards the partial window; so does clear.
  assign w_flush  = clear || !enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_ram_address  <= '0;
      r_ram_data     <= '0;
      r_ram_wren     <= 1'b0;
      r_buf_full     <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_ram_wren <= 1'b0;
      if (clear) begin
        r_wr_ptr       <= '0;
        r_buf_full     <= 1'b0;
        r_sample_count <= '0;
        r_state        <= enable ? RUN : IDLE;
      end else begin
        if (w_write) begin
          r_ram_wren    <= 1'b1;
          r_ram_address <= r_wr_ptr;
          r_ram_data    <= adc_data;
          r_wr_ptr      <= r_wr_ptr + 1'b1;
          if (r_sample_count != DEPTH) begin
            r_sample_count <= r_sample_count + 1'b1;
          end
          if (w_last) begin
            r_buf_full <= 1'b1;
          end
        end
        case (r_state)
          IDLE: if (enable) r_state <= (STOP_MODE && r_buf_full) ? FULL : RUN;
          RUN: begin
            if (!enable) r_state <= IDLE;
            else if (STOP_MODE && w_write && w_last) r_state <= FULL;
          end
          FULL: if (!enable) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  adc_window_avg #(
    .ADC_W   (ADC_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(w_accept),
    .sample      (adc_data),
    .flush       (w_flush),
    .avg_data    (w_avg_data),
    .avg_valid   (w_avg_valid),
    .avg_next    (w_avg_next),
    .win_done    (w_win_done)
  );

`ifdef ADC_LOG_ALARM_EN
  logic r_alarm;

  // Compare the average being committed so alarm rises with avg_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm <= 1'b0;
    end else if (clear) begin
      r_alarm <= 1'b0;
    end else if (w_win_done && (w_avg_next > alarm_thresh)) begin
      r_alarm <= 1'b1;
    end
  end

  assign alarm = r_alarm;
`else
  logic w_unused_alarm;

  assign w_unused_alarm = ^{alarm_thresh, w_avg_next, w_win_done};
  assign alarm          = 1'b0;
`endif

  assign ram_address  = r_ram_address;
  assign ram_data     = r_ram_data;
  assign ram_wren     = r_ram_wren;
  assign avg_data     = w_avg_data;
  assign avg_valid    = w_avg_valid;
  assign led          = w_avg_data[ADC_W-1 -: LED_W];
  assign buf_full     = r_buf_full;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_adc_sample_logger.sv
// tb/tb_adc_sample_logger.sv - directed self-checking bench for adc_sample_logger
module tb_adc_sample_logger;

`ifdef ADC_LOG_ALARM_EN
  localparam logic EXP_ALARM = 1'b1;
`else
  localparam logic EXP_ALARM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic [11:0] alarm_thresh = 12'hFFF;

  logic [3:0]  addr_w, addr_s;
  logic [11:0] data_w, data_s, avg_w, avg_s;
  logic        wren_w, wren_s, avgv_w, avgv_s, full_w, full_s, alarm_w, alarm_s;
  logic [7:0]  led_w, led_s;
  logic [4:0]  cnt_w, cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0]  qa_w[$], qa_s[$];
  logic [11:0] qd_w[$], qd_s[$], qv_w[$], qv_s[$];
  logic [7:0]  ql_w[$], ql_s[$];
  int          qc_w[$], qvc_w[$];

  adc_sample_logger #(.ADC_W(12), .ADDR_W(4), .AVG_LOG2(4), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .adc_valid(adc_valid), .adc_data(adc_data), .alarm_thresh(alarm_thresh),
    .ram_address(addr_w), .ram_data(data_w), .ram_wren(wren_w),
    .avg_data(avg_w), .avg_valid(avgv_w), .led(led_w),
    .buf_full(full_w), .sample_count(cnt_w), .alarm(alarm_w)
  );

  adc_sample_logger #(.ADC_W(12), .ADDR_W(4), .AVG_LOG2(4), .WRAP(0)) u_stop (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .adc_valid(adc_valid), .adc_data(adc_data), .alarm_thresh(alarm_thresh),
    .ram_address(addr_s), .ram_data(data_s), .ram_wren(wren_s),
    .avg_data(avg_s), .avg_valid(avgv_s), .led(led_s),
    .buf_full(full_s), .sample_count(cnt_s), .alarm(alarm_s)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (wren_w) begin qa_w.push_back(addr_w); qd_w.push_back(data_w); qc_w.push_back(cyc); end
      if (wren_s) begin qa_s.push_back(addr_s); qd_s.push_back(data_s); end
      if (avgv_w) begin qv_w.push_back(avg_w); ql_w.push_back(led_w); qvc_w.push_back(cyc); end
      if (avgv_s) begin qv_s.push_back(avg_s); ql_s.push_back(led_s); end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [11:0] v);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = v;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    adc_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic flush_q();
    qa_w.delete(); qd_w.delete(); qc_w.delete(); qv_w.delete(); ql_w.delete(); qvc_w.delete();
    qa_s.delete(); qd_s.delete(); qv_s.delete(); ql_s.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_wren", {31'd0, wren_w}, 0);
    check_eq("rst_addr", {28'd0, addr_w}, 0);
    check_eq("rst_avg", {20'd0, avg_w}, 0);
    check_eq("rst_led", {24'd0, led_w}, 0);
    check_eq("rst_full", {31'd0, full_s}, 0);
    check_eq("rst_cnt", {27'd0, cnt_w}, 0);
    check_eq("rst_alarm", {31'd0, alarm_w}, 0);

    rst = 1'b1;
    enable = 1'b1;

    // 16 x 0x800: addresses 0..15, one average 0x800
    flush_q();
    for (int i = 0; i < 16; i++) send(12'h800);
    idle(2);
    check_eq("t1_nwr", qa_w.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("t1_addr%0d", i), {28'd0, qa_w[i]}, i);
      check_eq($sformatf("t1_data%0d", i), {20'd0, qd_w[i]}, 32'h800);
    end
    check_eq("t1_navg", qv_w.size(), 1);
    check_eq("t1_avg", {20'd0, qv_w[0]}, 32'h800);
    check_eq("t1_led", {24'd0, ql_w[0]}, 32'h80);
    check_eq("t1_avg_lat", qvc_w[0], qc_w[15]);
    check_eq("t1_cnt", {27'd0, cnt_w}, 16);
    check_eq("t1_full_w", {31'd0, full_w}, 1);
    check_eq("t1_full_s", {31'd0, full_s}, 1);

    // Truncation plus stop-when-full / circular over 20 samples
    pulse_clear();
    flush_q();
    check_eq("t2_full_clr", {31'd0, full_s}, 0);
    check_eq("t2_cnt_clr", {27'd0, cnt_s}, 0);
    for (int i = 0; i < 20; i++) begin
      send((i < 16) ? 12'(i) : 12'h123);
      if (i == 15) check_eq("t2_full_pre", {31'd0, full_s}, 0);
      if (i == 16) check_eq("t2_full_post", {31'd0, full_s}, 1);
    end
    idle(2);
    check_eq("t2_nwr_w", qa_w.size(), 20);
    check_eq("t2_nwr_s", qa_s.size(), 16);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("t2_addr_w%0d", i), {28'd0, qa_w[i]}, i % 16);
      check_eq($sformatf("t2_data_w%0d", i), {20'd0, qd_w[i]}, (i < 16) ? i : 32'h123);
    end
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("t2_addr_s%0d", i), {28'd0, qa_s[i]}, i);
    check_eq("t2_navg", qv_w.size(), 1);
    check_eq("t2_avg", {20'd0, qv_w[0]}, 32'h007);
    check_eq("t2_led", {24'd0, ql_w[0]}, 32'h00);
    check_eq("t2_avg_s", {20'd0, qv_s[0]}, 32'h007);
    check_eq("t2_cnt_w", {27'd0, cnt_w}, 16);
    check_eq("t2_cnt_s", {27'd0, cnt_s}, 16);
    check_eq("t2_full_w", {31'd0, full_w}, 1);

    // Enable drop mid-window
    pulse_clear();
    for (int i = 0; i < 5; i++) send(12'hFFF);
    @(negedge clk);
    adc_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush_q();
    @(negedge clk);
    check_eq("t3_cnt_idle", {27'd0, cnt_w}, 5);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) send(12'h400);
    idle(2);
    check_eq("t3_nwr_w", qa_w.size(), 16);
    check_eq("t3_addr0_w", {28'd0, qa_w[0]}, 5);
    check_eq("t3_addr15_w", {28'd0, qa_w[15]}, 4);
    check_eq("t3_nwr_s", qa_s.size(), 11);
    check_eq("t3_addr0_s", {28'd0, qa_s[0]}, 5);
    check_eq("t3_navg", qv_w.size(), 1);
    check_eq("t3_avg", {20'd0, qv_w[0]}, 32'h400);
    check_eq("t3_led", {24'd0, ql_w[0]}, 32'h40);
    check_eq("t3_avg_s", {20'd0, qv_s[0]}, 32'h400);
    check_eq("t3_cnt_w", {27'd0, cnt_w}, 16);

    // clear coincident with adc_valid drops that sample
    flush_q();
    @(negedge clk);
    clear = 1'b1;
    adc_valid = 1'b1;
    adc_data = 12'h555;
    @(negedge clk);
    clear = 1'b0;
    adc_data = 12'h111;
    idle(2);
    check_eq("t4_nwr_w", qa_w.size(), 1);
    check_eq("t4_addr_w", {28'd0, qa_w[0]}, 0);
    check_eq("t4_data_w", {20'd0, qd_w[0]}, 32'h111);
    check_eq("t4_nwr_s", qa_s.size(), 1);
    check_eq("t4_addr_s", {28'd0, qa_s[0]}, 0);
    check_eq("t4_cnt", {27'd0, cnt_w}, 1);

    // Alarm: 0x800 over threshold 0x7FF, then 0x100 keeps it sticky
    pulse_clear();
    alarm_thresh = 12'h7FF;
    check_eq("t5_alarm_clr", {31'd0, alarm_w}, 0);
    for (int i = 0; i < 16; i++) send(12'h800);
    idle(2);
    check_eq("t5_avg1", {20'd0, avg_w}, 32'h800);
    check_eq("t5_alarm1_w", {31'd0, alarm_w}, {31'd0, EXP_ALARM});
    check_eq("t5_alarm1_s", {31'd0, alarm_s}, {31'd0, EXP_ALARM});
    for (int i = 0; i < 16; i++) send(12'h100);
    idle(2);
    check_eq("t5_avg2", {20'd0, avg_w}, 32'h100);
    check_eq("t5_led2", {24'd0, led_w}, 32'h10);
    check_eq("t5_alarm2", {31'd0, alarm_w}, {31'd0, EXP_ALARM});

    // Async reset mid-window, while a write pulse is showing
    for (int i = 0; i < 3; i++) send(12'h222);
    @(negedge clk);
    adc_valid = 1'b0;
    check_eq("t6_wren_pre", {31'd0, wren_w}, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_wren", {31'd0, wren_w}, 0);
    check_eq("t6_addr", {28'd0, addr_w}, 0);
    check_eq("t6_data", {20'd0, data_w}, 0);
    check_eq("t6_avg", {20'd0, avg_w}, 0);
    check_eq("t6_led", {24'd0, led_w}, 0);
    check_eq("t6_full", {31'd0, full_w}, 0);
    check_eq("t6_cnt", {27'd0, cnt_w}, 0);
    check_eq("t6_alarm", {31'd0, alarm_w}, 0);
    check_eq("t6_cnt_s", {27'd0, cnt_s}, 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
